spi_mem_master: RTL and testbench
=================================

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address bits sent per frame; legal values 16 or 24.
REQ-002 SHALL have parameter DIV, default 1: SCK half-period in clk cycles; legal values 1 to 255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a transaction request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = WRITE (0x02), 0 = READ (0x03).
REQ-008 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-009 SHALL have port req_wdata, input, 8 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse when a transaction completes.
REQ-011 SHALL have port rsp_rdata, output, 8 bits: read data; valid while rsp_valid=1 and held until the next read completes.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-013 SHALL have ports spi_cs_n (output, 1 bit), spi_sck (output, 1 bit), spi_mosi (output, 1 bit) and spi_miso (input, 1 bit).

Function
REQ-014 SHALL implement SPI mode 0: SCK idles low; MOSI changes only while SCK is low; MISO is sampled on the clk cycle in which SCK rises.
REQ-015 SHALL use states IDLE, CMD, ADDR, DATA, GAP.
REQ-016 SHALL, in IDLE, drive req_ready=1, and accept a request on the cycle where req_valid=1 and req_ready=1 (cycle T); inputs are captured at T.
REQ-017 SHALL drive req_ready=0 in every state other than IDLE; req_valid in those states is ignored.
REQ-018 SHALL, at T+1, drive spi_cs_n=0 and spi_mosi=command bit 7, and enter CMD.
REQ-019 SHALL give every bit DIV clk cycles with SCK low, followed by DIV cycles with SCK high.
REQ-020 SHALL shift bits MSB first in this order: 8 command bits (CMD), ADDR_W address bits (ADDR), then 8 data bits (DATA).
REQ-021 SHALL, for a write, drive req_wdata on MOSI during DATA.
REQ-022 SHALL, for a read, drive MOSI=0 during DATA and shift MISO into the receive register, MSB first.
REQ-023 SHALL define N = 16+ADDR_W bits per frame; the frame occupies cycles T+1 through T+2*DIV*N.
REQ-024 SHALL, at cycle T+2*DIV*N+1, drive spi_cs_n=1, spi_sck=0, spi_mosi=0, pulse rsp_valid for exactly 1 cycle, and enter GAP.
REQ-025 SHALL update rsp_rdata in the rsp_valid cycle of a read; a write leaves rsp_rdata unchanged.
REQ-026 SHALL remain in GAP for DIV cycles, keeping spi_cs_n=1, then return to IDLE; the earliest next acceptance is therefore T+2*DIV*N+1+DIV.
REQ-027 SHALL produce exactly N rising SCK edges per frame, with no SCK edge while spi_cs_n=1.
REQ-028 SHALL wrap the address without special handling; 0xFFFF (ADDR_W=16) is sent as-is.

Reset
REQ-029 SHALL, when rst_n=0 at a clk edge, force state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0x00, busy=0 and req_ready=0.
REQ-030 SHALL drive req_ready=1 from the first cycle after rst_n returns to 1.
REQ-031 SHALL, on a reset mid-frame, abort the frame immediately with no rsp_valid pulse; spi_cs_n is 1 from the cycle after the reset edge.

Verification
REQ-032 SHALL verify a READ with ADDR_W=16, DIV=1, model byte mem[0x0003]=0x80: request read at 0x0003 -> MOSI carries 0x03, 0x00, 0x03; exactly 32 SCK rises; rsp_valid at T+65 with rsp_rdata=0x80.
REQ-033 SHALL verify a WRITE then READ: write 0xA5 to 0x0010, then read 0x0010 -> model holds 0xA5; read rsp_rdata=0xA5; rsp_rdata is unchanged across the write.
REQ-034 SHALL verify back-to-back requests: req_valid held high across two requests -> the second is accepted exactly DIV cycles after the first rsp_valid; there is no acceptance while busy=1.
REQ-035 SHALL verify parameters ADDR_W=24, DIV=3: read at 0x123456 -> 40 SCK rises; SCK high and low phases are each 3 cycles; rsp_valid at T+241.
REQ-036 SHALL verify reset mid-frame: rst_n=0 during ADDR -> next cycle spi_cs_n=1, sck=0, rsp_valid never pulses; after release, a new read completes correctly.
REQ-037 SHALL verify an all-ones pattern: mem[0xFFFF]=0xFF, read at 0xFFFF -> 16 address bits of 1, rsp_rdata=0xFF.

Source files
------------

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for byte-wide serial memories.
// Each request sends one frame on MOSI: an 8-bit command (0x02 write or
// 0x03 read), then ADDR_W address bits, then 8 data bits, all MSB first.
// A read shifts MISO in during the data byte. After each frame the block
// holds chip-select high for DIV cycles before it accepts the next request.
module spi_mem_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIV    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned FRAME_W = 16 + ADDR_W;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DIV_W   = 8;

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] ADDR_FIRST = BIT_W'(8);
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(8 + ADDR_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]         state_q,     state_d;
  logic [DIV_W-1:0]   div_q,       div_d;
  logic [BIT_W-1:0]   bit_q,       bit_d;
  logic [FRAME_W-1:0] shift_q,     shift_d;
  logic [7:0]         rx_q,        rx_d;
  logic               write_q,     write_d;
  logic               ready_q,     ready_d;
  logic               busy_q,      busy_d;
  logic               cs_n_q,      cs_n_d;
  logic               sck_q,       sck_d;
  logic               mosi_q,      mosi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rdata_q,     rdata_d;

  logic [FRAME_W-1:0] load_frame;
  logic               phase_end;

  // Whole outgoing frame; a read sends zeros in the data byte.
  assign load_frame = {(req_write ? CMD_WRITE : CMD_READ), req_addr,
                       (req_write ? req_wdata : 8'h00)};
  assign phase_end  = (div_q == DIV_LAST);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_q        <= 8'h00;
      write_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      write_q     <= write_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next state: half-bit timing, bit sequencing, MISO capture and response.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    write_d     = write_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (req_valid && ready_q) begin
          state_d = S_CMD;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          write_d = req_write;
          shift_d = load_frame;
          mosi_d  = load_frame[FRAME_W-1];
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (phase_end) begin
          div_d = '0;
          if (!sck_q) begin
            // Rising SCK: this is the cycle in which MISO is captured.
            sck_d = 1'b1;
            if (state_q == S_DATA) begin
              rx_d = {rx_q[6:0], spi_miso};
            end
          end else begin
            // Falling SCK: MOSI advances to the next bit.
            sck_d   = 1'b0;
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            mosi_d  = shift_q[FRAME_W-2];
            if (bit_q == LAST_BIT) begin
              state_d     = S_GAP;
              cs_n_d      = 1'b1;
              mosi_d      = 1'b0;
              rsp_valid_d = 1'b1;
              if (!write_q) begin
                rdata_d = rx_q;
              end
            end else if (bit_d == ADDR_FIRST) begin
              state_d = S_ADDR;
            end else if (bit_d == DATA_FIRST) begin
              state_d = S_DATA;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (phase_end) begin
          state_d = S_IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: instance 0 (ADDR_W=16, DIV=1) and instance 1
// (ADDR_W=24, DIV=3) are checked every cycle against a timeline model,
// with a SPI memory slave behind each one.
`timescale 1ns/1ps
module tb_spi_mem_master;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]  req_valid, req_write, miso;
  logic [31:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic [1:0]  rdy, rv, bsy, csn, sck, mosi;
  logic [7:0]  rdata [2];

  int checks = 0;
  int errors = 0;

  // Timeline model state
  int          cyc;
  logic        rst_prev;
  bit          m_active [2];
  int          m_T      [2];
  logic        m_wr     [2];
  logic [31:0] m_addr   [2];
  logic [7:0]  m_wd     [2];
  logic [7:0]  m_rd     [2];
  logic [7:0]  m_rdnew  [2];
  int acc_cnt [2], acc_cyc [2], rsp_cnt [2], rsp_cyc [2], hi_cyc [2], lo_cyc [2];

  // SPI memory slave state
  logic        sprev  [2];
  int          sbits  [2];
  logic [63:0] ssr    [2];
  logic [7:0]  s_cmd  [2];
  logic [31:0] s_addr [2];
  int          last_rises [2];
  logic [7:0]  last_cmd   [2];
  logic [31:0] last_addr  [2];
  logic [7:0]  last_data  [2];

  logic [7:0] smem [longint unsigned];
  logic [7:0] mmem [longint unsigned];

  always #5 clk = ~clk;

  spi_mem_master #(.ADDR_W(16), .DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0][15:0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .busy(bsy[0]),
    .spi_cs_n(csn[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_mem_master #(.ADDR_W(24), .DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1][23:0]), .req_wdata(req_wdata[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .busy(bsy[1]),
    .spi_cs_n(csn[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  function automatic int aw(input int i);
    return (i == 0) ? 16 : 24;
  endfunction

  function automatic int dv(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic longint unsigned key(input int i, input logic [31:0] a);
    return (64'(i) << 32) | 64'(a);
  endfunction

  function automatic logic [7:0] s_rd(input longint unsigned k);
    return smem.exists(k) ? smem[k] : 8'h00;
  endfunction

  function automatic logic [7:0] m_get(input longint unsigned k);
    return mmem.exists(k) ? mmem[k] : 8'h00;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then the SPI slave update.
  initial begin
    logic e_rdy, e_rv, e_bsy, e_csn, e_sck, e_mosi;
    logic [63:0] frame;
    logic [31:0] mask;
    logic [7:0]  sb;
    int rel, n, d, a, b, ph, k;
    cyc = 0;
    rst_prev = 1'b0;
    miso = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_T[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
      m_rd[i] = 0; m_rdnew[i] = 0; acc_cnt[i] = 0; acc_cyc[i] = 0;
      rsp_cnt[i] = 0; rsp_cyc[i] = 0; hi_cyc[i] = 0; lo_cyc[i] = 0;
      sprev[i] = 0; sbits[i] = 0; ssr[i] = 0; s_cmd[i] = 0; s_addr[i] = 0;
      last_rises[i] = 0; last_cmd[i] = 0; last_addr[i] = 0; last_data[i] = 0;
    end
    smem[key(0, 32'h0003)] = 8'h80;   mmem[key(0, 32'h0003)] = 8'h80;
    smem[key(0, 32'hFFFF)] = 8'hFF;   mmem[key(0, 32'hFFFF)] = 8'hFF;
    smem[key(1, 32'h123456)] = 8'h5C; mmem[key(1, 32'h123456)] = 8'h5C;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        a = aw(i); d = dv(i); n = 16 + a;
        mask = (32'h1 << a) - 32'h1;
        e_rdy = 0; e_rv = 0; e_bsy = 0; e_csn = 1; e_sck = 0; e_mosi = 0;
        if (!rst_prev) begin
          m_active[i] = 0;
          m_rd[i] = 8'h00;
        end else if (!m_active[i]) begin
          e_rdy = 1;
        end else begin
          rel = cyc - m_T[i];
          e_bsy = 1;
          if (rel <= 2 * d * n) begin
            b  = (rel - 1) / (2 * d);
            ph = (rel - 1) % (2 * d);
            frame = (64'(m_wr[i] ? 8'h02 : 8'h03) << (a + 8)) | (64'(m_addr[i]) << 8)
                  | 64'(m_wr[i] ? m_wd[i] : 8'h00);
            e_csn  = 0;
            e_sck  = (ph >= d);
            e_mosi = frame[n - 1 - b];
          end else if (rel == 2 * d * n + 1) begin
            e_rv = 1;
            if (!m_wr[i]) m_rd[i] = m_rdnew[i];
          end
        end
        chk("req_ready", i, 64'(rdy[i]), 64'(e_rdy));
        chk("rsp_valid", i, 64'(rv[i]), 64'(e_rv));
        chk("busy",      i, 64'(bsy[i]), 64'(e_bsy));
        chk("spi_cs_n",  i, 64'(csn[i]), 64'(e_csn));
        chk("spi_sck",   i, 64'(sck[i]), 64'(e_sck));
        chk("spi_mosi",  i, 64'(mosi[i]), 64'(e_mosi));
        chk("rsp_rdata", i, 64'(rdata[i]), 64'(m_rd[i]));
        if (rv[i] === 1'b1) begin rsp_cnt[i]++; rsp_cyc[i] = cyc; end
        if (csn[i] === 1'b0) begin
          if (sck[i] === 1'b1) hi_cyc[i]++; else lo_cyc[i]++;
        end
        // Model: what the block does at the coming edge
        if (!rst_n) begin
          m_active[i] = 0;
        end else if (m_active[i] && (cyc - m_T[i]) == 2 * d * n + d) begin
          m_active[i] = 0;
        end else if (e_rdy && req_valid[i]) begin
          m_active[i] = 1; m_T[i] = cyc; m_wr[i] = req_write[i];
          m_addr[i] = req_addr[i] & mask; m_wd[i] = req_wdata[i];
          acc_cnt[i]++; acc_cyc[i] = cyc; hi_cyc[i] = 0; lo_cyc[i] = 0;
          if (m_wr[i]) mmem[key(i, m_addr[i])] = m_wd[i];
          else m_rdnew[i] = m_get(key(i, m_addr[i]));
        end
        // Slave: capture MOSI on SCK rise, drive MISO while SCK is low
        if (csn[i] !== 1'b0) begin
          if (sbits[i] != 0) begin
            last_rises[i] = sbits[i]; last_cmd[i] = s_cmd[i];
            last_addr[i] = s_addr[i]; last_data[i] = ssr[i][7:0];
            if (sbits[i] == n && s_cmd[i] == 8'h02) smem[key(i, s_addr[i])] = ssr[i][7:0];
          end
          sbits[i] = 0;
          miso[i] = 1'b0;
        end else begin
          if (sck[i] === 1'b1 && sprev[i] === 1'b0) begin
            ssr[i] = {ssr[i][62:0], mosi[i]};
            sbits[i]++;
            if (sbits[i] == 8 + a) begin
              s_cmd[i]  = 8'(ssr[i] >> a);
              s_addr[i] = 32'(ssr[i]) & mask;
            end
          end
          if (sck[i] === 1'b0) begin
            k = sbits[i];
            if (k >= 8 + a && k < n && s_cmd[i] == 8'h03) begin
              sb = s_rd(key(i, s_addr[i]));
              miso[i] = sb[7 - (k - 8 - a)];
            end else begin
              miso[i] = 1'b0;
            end
          end
        end
        sprev[i] = sck[i];
      end
      rst_prev = rst_n;
    end
  end

  // Present a request from posedge+1 and hold until the model accepts it.
  task automatic issue(input int i, input logic w, input logic [31:0] a,
                       input logic [7:0] wd, input bit hold);
    int a0;
    int k;
    a0 = acc_cnt[i];
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = wd;
    k = 0;
    while (acc_cnt[i] == a0 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    if (!hold) req_valid[i] = 1'b0;
    chk("accept", i, 64'(acc_cnt[i] - a0), 64'd1);
  endtask

  task automatic wait_done(input int i);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (bsy[i] !== 1'b0 && k < 3000);
    chk("done", i, 64'(bsy[i]), 64'd0);
  endtask

  initial begin
    int rc, a1;
    req_valid = 2'b00; req_write = 2'b00;
    req_addr[0] = 0; req_addr[1] = 0; req_wdata[0] = 0; req_wdata[1] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 0, 64'(rdy[0]), 64'd1);
    chk("rdata_after_reset", 0, 64'(rdata[0]), 64'h00);

    // Read 0x0003 on the 16-bit / DIV=1 instance
    issue(0, 1'b0, 32'h0003, 8'h00, 0);
    wait_done(0);
    chk("rd_latency", 0, 64'(rsp_cyc[0] - acc_cyc[0]), 64'd65);
    chk("rd_data",    0, 64'(rdata[0]), 64'h80);
    chk("rd_cmd",     0, 64'(last_cmd[0]), 64'h03);
    chk("rd_addr",    0, 64'(last_addr[0]), 64'h0003);
    chk("rd_rises",   0, 64'(last_rises[0]), 64'd32);
    chk("rd_mosi_data", 0, 64'(last_data[0]), 64'h00);

    // Write 0xA5 to 0x0010, then read it back
    issue(0, 1'b1, 32'h0010, 8'hA5, 0);
    wait_done(0);
    chk("wr_rdata_held", 0, 64'(rdata[0]), 64'h80);
    chk("wr_cmd",        0, 64'(last_cmd[0]), 64'h02);
    chk("wr_mem",        0, 64'(s_rd(key(0, 32'h0010))), 64'hA5);
    issue(0, 1'b0, 32'h0010, 8'h00, 0);
    wait_done(0);
    chk("rd_back", 0, 64'(rdata[0]), 64'hA5);

    // Back-to-back: req_valid stays high across two requests
    issue(0, 1'b0, 32'h0003, 8'h00, 1);
    a1 = acc_cyc[0];
    issue(0, 1'b1, 32'h0020, 8'h5A, 0);
    chk("b2b_gap",   0, 64'(acc_cyc[0] - rsp_cyc[0]), 64'd1);
    chk("b2b_accept", 0, 64'(acc_cyc[0] - a1), 64'd66);
    wait_done(0);
    chk("b2b_wr_mem", 0, 64'(s_rd(key(0, 32'h0020))), 64'h5A);
    chk("b2b_rdata",  0, 64'(rdata[0]), 64'h80);

    // 24-bit address, DIV=3
    issue(1, 1'b0, 32'h123456, 8'h00, 0);
    wait_done(1);
    chk("w24_latency", 1, 64'(rsp_cyc[1] - acc_cyc[1]), 64'd241);
    chk("w24_rises",   1, 64'(last_rises[1]), 64'd40);
    chk("w24_addr",    1, 64'(last_addr[1]), 64'h123456);
    chk("w24_hi_cyc",  1, 64'(hi_cyc[1]), 64'd120);
    chk("w24_lo_cyc",  1, 64'(lo_cyc[1]), 64'd120);
    chk("w24_data",    1, 64'(rdata[1]), 64'h5C);

    // Reset in the middle of the address phase
    issue(0, 1'b0, 32'h0003, 8'h00, 0);
    repeat (30) @(posedge clk);
    #1;
    rc = rsp_cnt[0];
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_cs_n", 0, 64'(csn[0]), 64'd1);
    chk("rst_sck",  0, 64'(sck[0]), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_rsp", 0, 64'(rsp_cnt[0] - rc), 64'd0);
    chk("rst_rdata",  0, 64'(rdata[0]), 64'h00);
    issue(0, 1'b0, 32'h0003, 8'h00, 0);
    wait_done(0);
    chk("post_rst_data", 0, 64'(rdata[0]), 64'h80);

    // All-ones address and data
    issue(0, 1'b0, 32'hFFFF, 8'h00, 0);
    wait_done(0);
    chk("ones_addr",  0, 64'(last_addr[0]), 64'hFFFF);
    chk("ones_rises", 0, 64'(last_rises[0]), 64'd32);
    chk("ones_data",  0, 64'(rdata[0]), 64'hFF);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
